// File: rtl/mult_accum_datapath.sv
`timescale 1ns / 1ps
// ---------------------------------------------------------------------------------------------
// mult_accum_datapath
//
// Purpose:
//   Datapath for a shift-add multiplier. It responds to the AccLD/AccCLR/SRSEL strobes from the
//   multiply control FSM. It holds the shifting multiplicand (SR) and the accumulator (ACC),
//   tracks each multiply sequence, and publishes a registered product with a one-cycle Done
//   pulse. A sticky protocol-error flag is also provided.
//
// Parameters:
//   W        operand width; SR, ACC and Product are 2*W bits wide
//
// Ports:
//   clk      in   1     system clock, all state on rising edge
//   rst      in   1     asynchronous, active-high reset
//   A        in   W     multiplicand, loaded into SR when SRSEL==1
//   B        in   W     multiplier, sampled on AccCLR (self-check only)
//   AccLD    in   1     add SR into ACC this cycle
//   AccCLR   in   1     clear ACC and start a new sequence
//   SRSEL    in   2     0=hold 1=load A 2=shift left 3=illegal (hold + SeqErr)
//   Product  out  2W    registered result of the last completed sequence
//   Done     out  1     one-cycle pulse, first cycle Product holds a new result
//   Busy     out  1     high while a sequence is in progress
//   SeqErr   out  1     sticky protocol-error flag, cleared only by rst
//   ChkErr   out  1     sticky self-check mismatch flag
//
// Configuration:
//   MULT_CHECK_EN  when defined, A and B are shadowed on AccCLR. At completion the final ACC is
//                  compared with shadowA*shadowB, and any mismatch sets ChkErr. When the macro
//                  is undefined, ChkErr is tied low and B is unused.
// ---------------------------------------------------------------------------------------------
module mult_accum_datapath #(
   parameter int unsigned W = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [W-1:0]   A,
   input  logic [W-1:0]   B,
   input  logic           AccLD,
   input  logic           AccCLR,
   input  logic [1:0]     SRSEL,
   output logic [2*W-1:0] Product,
   output logic           Done,
   output logic           Busy,
   output logic           SeqErr,
   output logic           ChkErr
);

   localparam int unsigned PW    = 2 * W;
   localparam int unsigned StepW = (W > 1) ? $clog2(W) : 1;
   localparam logic [StepW-1:0] LastStep = StepW'(W - 1);

   typedef enum logic {
      StIdle,
      StArmed
   } state_e;

   state_e           r_state;
   state_e           w_state_next;
   logic [StepW-1:0] r_step;
   logic [StepW-1:0] w_step_next;
   logic [PW-1:0]    r_sr;
   logic [PW-1:0]    w_sr_next;
   logic [PW-1:0]    r_acc;
   logic [PW-1:0]    w_acc_next;
   logic [PW-1:0]    r_product;
   logic             r_done;
   logic             r_seq_err;
   logic             w_complete;
   logic             w_proto_err;

   // ------------------------------------------------------------------------------------------
   // Shift register next state
   // ------------------------------------------------------------------------------------------
   always_comb begin
      w_sr_next = r_sr;
      case (SRSEL)
         2'd0:    w_sr_next = r_sr;
         2'd1:    w_sr_next = {{W{1'b0}}, A};
         2'd2:    w_sr_next = {r_sr[PW-2:0], 1'b0};
         default: w_sr_next = r_sr;
      endcase
   end

   // ------------------------------------------------------------------------------------------
   // Accumulator next state. The add uses the pre-shift SR of the same cycle. The clear wins
   // over the load.
   // ------------------------------------------------------------------------------------------
   always_comb begin
      w_acc_next = r_acc;
      if (AccCLR) begin
         w_acc_next = '0;
      end else if (AccLD) begin
         w_acc_next = r_acc + r_sr;
      end
   end

   assign w_proto_err = (SRSEL == 2'd3) || (AccCLR && AccLD);

   // ------------------------------------------------------------------------------------------
   // Sequence tracker. A clear while armed restarts the count, even in the last bit cycle, so
   // an aborted sequence never completes.
   // ------------------------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_step_next  = r_step;
      w_complete   = 1'b0;
      case (r_state)
         StIdle: begin
            if (AccCLR) begin
               w_state_next = StArmed;
               w_step_next  = '0;
            end
         end
         StArmed: begin
            if (AccCLR) begin
               w_step_next = '0;
            end else if (r_step == LastStep) begin
               w_complete   = 1'b1;
               w_state_next = StIdle;
               w_step_next  = '0;
            end else begin
               w_step_next = r_step + StepW'(1);
            end
         end
         default: begin
            w_state_next = StIdle;
            w_step_next  = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= StIdle;
         r_step    <= '0;
         r_sr      <= '0;
         r_acc     <= '0;
         r_product <= '0;
         r_done    <= 1'b0;
         r_seq_err <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_step    <= w_step_next;
         r_sr      <= w_sr_next;
         r_acc     <= w_acc_next;
         r_done    <= w_complete;
         r_seq_err <= r_seq_err | w_proto_err;
         if (w_complete) begin
            r_product <= w_acc_next;
         end
      end
   end

   assign Product = r_product;
   assign Done    = r_done;
   assign Busy    = (r_state == StArmed);
   assign SeqErr  = r_seq_err;

   // ------------------------------------------------------------------------------------------
   // Optional self-check against a reference multiply of the operands seen at AccCLR
   // ------------------------------------------------------------------------------------------
`ifdef MULT_CHECK_EN
   logic [W-1:0]  r_shadow_a;
   logic [W-1:0]  r_shadow_b;
   logic [PW-1:0] w_ref_product;
   logic          r_chk_err;

   assign w_ref_product = PW'(r_shadow_a) * PW'(r_shadow_b);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shadow_a <= '0;
         r_shadow_b <= '0;
         r_chk_err  <= 1'b0;
      end else begin
         if (AccCLR) begin
            r_shadow_a <= A;
            r_shadow_b <= B;
         end
         // Completion never coincides with AccCLR, so the shadows here belong to this run.
         if (w_complete && (w_acc_next != w_ref_product)) begin
            r_chk_err <= 1'b1;
         end
      end
   end

   assign ChkErr = r_chk_err;
`else
   logic w_unused_b;

   // B only feeds the self-check.
   assign w_unused_b = ^B;
   assign ChkErr     = 1'b0;
`endif

endmodule

// File: tb/tb_mult_accum_datapath.sv
`timescale 1ns / 1ps
// ---------------------------------------------------------------------------------------------
// tb_mult_accum_datapath
//
// Self-checking bench for mult_accum_datapath (W=4). Expected products come from a model
// that works at the sequence level. The product is the sum of A shifted by the number of
// left-shifts preceding each loading bit cycle, taken modulo 256.
// ---------------------------------------------------------------------------------------------
module tb_mult_accum_datapath;

   localparam logic [7:0] StdSel = 8'h2A;  // bit cycles SRSEL = 2,2,2,0
   localparam logic [7:0] BadSel = 8'h2B;  // bit cycles SRSEL = 3,2,2,0

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] a;
   logic [3:0] b;
   logic       ld;
   logic       clr;
   logic [1:0] srsel;
   logic [7:0] product;
   logic       done;
   logic       busy;
   logic       seq_err;
   logic       chk_err;

   int         errors = 0;
   int         checks = 0;
   bit         exp_seq = 1'b0;
   bit         exp_chk = 1'b0;
   logic [7:0] last_prod = 8'h00;

   always #5 clk = ~clk;

   mult_accum_datapath #(
      .W(4)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .A      (a),
      .B      (b),
      .AccLD  (ld),
      .AccCLR (clr),
      .SRSEL  (srsel),
      .Product(product),
      .Done   (done),
      .Busy   (busy),
      .SeqErr (seq_err),
      .ChkErr (chk_err)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle;
      clr   = 1'b0;
      ld    = 1'b0;
      srsel = 2'd0;
   endtask

   function automatic logic [7:0] model_product(input logic [3:0] aa, input logic [7:0] srs,
                                                input logic [3:0] lds);
      int acc;
      int sh;
      acc = 0;
      sh  = 0;
      for (int i = 0; i < 4; i++) begin
         if (lds[i]) acc += int'(aa) << sh;
         if (srs[2*i+:2] == 2'd2) sh++;
      end
      return acc[7:0];
   endfunction

   // Drives one full sequence: a CLR+load cycle, then four bit cycles. It returns in the
   // Done cycle after checking the result, with the inputs left idle.
   task automatic run_seq(input logic [3:0] aa, input logic [3:0] bb, input logic [7:0] srs,
                          input logic [3:0] lds, input bit ld_on_clr, input string name);
      logic [7:0] expv;
      logic [7:0] full;
      expv  = model_product(aa, srs, lds);
      full  = {4'b0, aa} * {4'b0, bb};
      a     = aa;
      b     = bb;
      clr   = 1'b1;
      srsel = 2'd1;
      ld    = ld_on_clr;
      if (ld_on_clr) exp_seq = 1'b1;
      tick;
      for (int i = 0; i < 4; i++) begin
         clr   = 1'b0;
         srsel = srs[2*i+:2];
         ld    = lds[i];
         if (srsel == 2'd3) exp_seq = 1'b1;
         checks++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s bit%0d: busy=%b done=%b, want busy=1 done=0", name, i + 1, busy,
                     done);
         end
         tick;
      end
      drive_idle;
`ifdef MULT_CHECK_EN
      if (expv != full) exp_chk = 1'b1;
`endif
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL %s done: got %b want 1", name, done);
      end
      checks++;
      if (product !== expv) begin
         errors++;
         $display("FAIL %s product: got %h want %h (A=%0d B=%0d)", name, product, expv, aa, bb);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s busy after: got %b want 0", name, busy);
      end
      checks++;
      if (seq_err !== exp_seq) begin
         errors++;
         $display("FAIL %s seqerr: got %b want %b", name, seq_err, exp_seq);
      end
      checks++;
      if (chk_err !== exp_chk) begin
         errors++;
         $display("FAIL %s chkerr: got %b want %b", name, chk_err, exp_chk);
      end
      last_prod = expv;
   endtask

   task automatic quiet_cycle(input string name);
      tick;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || product !== last_prod) begin
         errors++;
         $display("FAIL %s quiet: done=%b busy=%b product=%h, want 0 0 %h", name, done, busy,
                  product, last_prod);
      end
   endtask

   task automatic check_all_zero(input string name);
      checks++;
      if ({product, done, busy, seq_err, chk_err} !== 12'h000) begin
         errors++;
         $display("FAIL %s: product=%h done=%b busy=%b seqerr=%b chkerr=%b, want all 0", name,
                  product, done, busy, seq_err, chk_err);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      a   = 4'd0;
      b   = 4'd0;
      drive_idle;
      tick;
      tick;
      check_all_zero("reset");
      rst = 1'b0;
      quiet_cycle("post_reset");
   endtask

   task automatic test_basic;
      run_seq(4'd13, 4'd11, StdSel, 4'b1011, 1'b0, "basic_13x11");
      checks++;
      if (product !== 8'h8F) begin
         errors++;
         $display("FAIL basic_const: got %h want 8f", product);
      end
      quiet_cycle("basic_pulse");
   endtask

   task automatic test_reset_mid;
      a     = 4'd7;
      b     = 4'd9;
      clr   = 1'b1;
      srsel = 2'd1;
      tick;
      clr   = 1'b0;
      srsel = 2'd2;
      ld    = 1'b1;
      #2 rst = 1'b1;
      #1 check_all_zero("reset_async");
      tick;
      check_all_zero("reset_mid");
      rst = 1'b0;
      drive_idle;
      exp_seq   = 1'b0;
      exp_chk   = 1'b0;
      last_prod = 8'h00;
      for (int i = 0; i < 6; i++) quiet_cycle("reset_no_done");
   endtask

   task automatic test_corners;
      run_seq(4'd15, 4'd15, StdSel, 4'b1111, 1'b0, "max_15x15");
      quiet_cycle("max_gap");
      run_seq(4'd0, 4'd9, StdSel, 4'b1001, 1'b0, "zero_a");
      quiet_cycle("zero_a_gap");
      run_seq(4'd12, 4'd0, StdSel, 4'b0000, 1'b0, "zero_b");
      quiet_cycle("zero_b_gap");
   endtask

   task automatic test_idle_ld;
      ld = 1'b1;
      for (int i = 0; i < 3; i++) quiet_cycle("idle_ld");
      drive_idle;
      run_seq(4'd5, 4'd3, StdSel, 4'b0011, 1'b0, "after_idle_ld");
      quiet_cycle("idle_ld_gap");
   endtask

   task automatic test_abort;
      for (int k = 1; k <= 3; k += 2) begin
         a     = 4'd3;
         b     = 4'd7;
         clr   = 1'b1;
         srsel = 2'd1;
         tick;
         for (int i = 0; i < k; i++) begin
            clr   = 1'b0;
            srsel = 2'd2;
            ld    = 1'b1;
            tick;
         end
         checks++;
         if (done !== 1'b0 || product !== last_prod) begin
            errors++;
            $display("FAIL abort_pre%0d: done=%b product=%h want 0 %h", k, done, product,
                     last_prod);
         end
         run_seq(4'd6, 4'd5, StdSel, 4'b0101, 1'b0, "abort_restart");
         quiet_cycle("abort_gap");
      end
   endtask

   task automatic test_seq_err;
      run_seq(4'd7, 4'd8, BadSel, 4'b1111, 1'b0, "srsel3_hold");
      quiet_cycle("srsel3_gap");
      run_seq(4'd9, 4'd6, StdSel, 4'b0110, 1'b1, "clr_ld_together");
      run_seq(4'd2, 4'd10, StdSel, 4'b1010, 1'b0, "seqerr_sticky");
      rst = 1'b1;
      tick;
      rst       = 1'b0;
      exp_seq   = 1'b0;
      exp_chk   = 1'b0;
      last_prod = 8'h00;
      check_all_zero("seqerr_cleared");
   endtask

   task automatic test_back_to_back;
      for (int n = 0; n < 24; n++) begin
         logic [3:0] ra;
         logic [3:0] rb;
         ra = 4'($urandom_range(0, 15));
         rb = 4'($urandom_range(0, 15));
         run_seq(ra, rb, StdSel, rb, 1'b0, "random");
         if ($urandom_range(0, 1) == 0) quiet_cycle("random_gap");
      end
      quiet_cycle("random_end");
   endtask

   task automatic test_check;
      run_seq(4'd9, 4'd3, StdSel, 4'b0010, 1'b0, "check_mismatch");
      quiet_cycle("check_gap");
      run_seq(4'd4, 4'd4, StdSel, 4'b0100, 1'b0, "check_sticky");
      quiet_cycle("check_end");
   endtask

   initial begin
      test_reset;
      test_basic;
      test_reset_mid;
      test_corners;
      test_idle_ld;
      test_abort;
      test_seq_err;
      test_back_to_back;
      test_check;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
